// File: rtl/inst_buffer_pkg.sv
// Shared types for the instruction buffer between fetch and the dual-issue decode slots.
package inst_buffer_pkg;

  localparam int unsigned INST_BUF_DEPTH = 16;

  typedef struct packed {
    logic [31:0] inst;
    logic [31:0] pc;
    logic        excp;
  } inst_entry_t;

endpackage

// File: rtl/inst_buffer_ram.sv
// Register-array storage for the instruction buffer: two write ports, two asynchronous read ports.
module inst_buffer_ram
  import inst_buffer_pkg::*;
#(
  parameter int unsigned DEPTH = INST_BUF_DEPTH,
  parameter int unsigned AW    = $clog2(DEPTH)
) (
  input  logic          clk_i,
  input  logic          we1_i,
  input  logic [AW-1:0] waddr1_i,
  input  inst_entry_t   wdata1_i,
  input  logic          we2_i,
  input  logic [AW-1:0] waddr2_i,
  input  inst_entry_t   wdata2_i,
  input  logic [AW-1:0] raddr1_i,
  output inst_entry_t   rdata1_o,
  input  logic [AW-1:0] raddr2_i,
  output inst_entry_t   rdata2_o
);

  inst_entry_t mem_q [DEPTH];
  inst_entry_t mem_d [DEPTH];

  // Storage is deliberately not reset; occupancy is tracked by the pointers.
  always_comb begin
    mem_d = mem_q;
    if (we1_i) mem_d[waddr1_i] = wdata1_i;
    if (we2_i) mem_d[waddr2_i] = wdata2_i;
  end

  always_ff @(posedge clk_i) begin
    mem_q <= mem_d;
  end

  assign rdata1_o = mem_q[raddr1_i];
  assign rdata2_o = mem_q[raddr2_i];

endmodule

// File: rtl/inst_buffer.sv
// Dual-push / dual-pop first-word-fall-through instruction FIFO feeding the master/slave decoders.
module inst_buffer
  import inst_buffer_pkg::*;
#(
  parameter int unsigned DEPTH = INST_BUF_DEPTH,
  parameter int unsigned AW    = $clog2(DEPTH)
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        flush,
  input  logic        write_en1,
  input  logic        write_en2,
  input  logic [31:0] write_inst1,
  input  logic [31:0] write_inst2,
  input  logic [31:0] write_addr1,
  input  logic [31:0] write_addr2,
  input  logic        write_excp1,
  input  logic        write_excp2,
  input  logic        read_en1,
  input  logic        read_en2,
  output logic [31:0] read_inst1,
  output logic [31:0] read_inst2,
  output logic [31:0] read_addr1,
  output logic [31:0] read_addr2,
  output logic        read_excp1,
  output logic        read_excp2,
  output logic        read_valid1,
  output logic        read_valid2,
  output logic        empty,
  output logic        full,
  output logic        almost_full
);

  localparam logic [AW:0]   CntFull = (AW+1)'(DEPTH);
  localparam logic [AW:0]   CntAf   = (AW+1)'(DEPTH - 2);
  localparam logic [AW:0]   CntTwo  = (AW+1)'(2);
  localparam logic [AW-1:0] PtrOne  = AW'(1);

  logic [AW-1:0] wr_ptr_q, wr_ptr_d;
  logic [AW-1:0] rd_ptr_q, rd_ptr_d;
  logic [AW:0]   count_q, count_d;
  logic [AW:0]   num_push, num_pop;
  logic          push1, push2, pop1, pop2;
  inst_entry_t   wdata1, wdata2, rdata1, rdata2;

  assign read_valid1 = (count_q != '0);
  assign read_valid2 = (count_q >= CntTwo);
  assign empty       = (count_q == '0);
  assign full        = (count_q == CntFull);
  assign almost_full = (count_q >= CntAf);

  always_comb begin
    pop1 = read_en1 & read_valid1;
    pop2 = read_en1 & read_en2 & read_valid2;
    // Capacity uses the registered count: same-cycle pops never make room.
    push1 = write_en1 & (count_q < CntFull);
    push2 = write_en1 & write_en2 & (count_q < (CntFull - 1'b1));
    num_push = (AW+1)'(push1) + (AW+1)'(push2);
    num_pop  = (AW+1)'(pop1) + (AW+1)'(pop2);
    wr_ptr_d = wr_ptr_q + num_push[AW-1:0];
    rd_ptr_d = rd_ptr_q + num_pop[AW-1:0];
    count_d  = count_q + num_push - num_pop;
    if (flush) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      count_d  = '0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  assign wdata1 = '{inst: write_inst1, pc: write_addr1, excp: write_excp1};
  assign wdata2 = '{inst: write_inst2, pc: write_addr2, excp: write_excp2};

  inst_buffer_ram #(
    .DEPTH (DEPTH),
    .AW    (AW)
  ) u_ram (
    .clk_i    (clk),
    .we1_i    (push1),
    .waddr1_i (wr_ptr_q),
    .wdata1_i (wdata1),
    .we2_i    (push2),
    .waddr2_i (wr_ptr_q + PtrOne),
    .wdata2_i (wdata2),
    .raddr1_i (rd_ptr_q),
    .rdata1_o (rdata1),
    .raddr2_i (rd_ptr_q + PtrOne),
    .rdata2_o (rdata2)
  );

  // Invalid slots read as all-zero so decode sees a NOP.
  assign read_inst1 = read_valid1 ? rdata1.inst : '0;
  assign read_addr1 = read_valid1 ? rdata1.pc   : '0;
  assign read_excp1 = read_valid1 ? rdata1.excp : 1'b0;
  assign read_inst2 = read_valid2 ? rdata2.inst : '0;
  assign read_addr2 = read_valid2 ? rdata2.pc   : '0;
  assign read_excp2 = read_valid2 ? rdata2.excp : 1'b0;

endmodule
